// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback requesters.
// Optional macro RFARB_R0_ZERO_EN: register 0 is hard-wired to zero (accepted writes to it are dropped).
module regfile_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        reqValid;
  logic [ADDR_W-1:0] reqAddr [2];
  logic [DATA_W-1:0] reqData [2];

  assign reqValid   = {req1_valid, req0_valid};
  assign reqAddr[0] = req0_addr;
  assign reqAddr[1] = req1_addr;
  assign reqData[0] = req0_data;
  assign reqData[1] = req1_data;

  logic              lastGrantReg, lastGrantNext;
  logic              writeEnableReg, writeEnableNext;
  logic [ADDR_W-1:0] writeAddrReg, writeAddrNext;
  logic [DATA_W-1:0] writeDataReg, writeDataNext;
  logic [CNT_W-1:0]  conflictReg, conflictNext;

  logic [1:0] grant;
  logic       transfer;
  logic       grantIdx;
  logic       bothValid;
  logic       dropWrite;

  assign bothValid = reqValid[0] && reqValid[1];

  // Ready is gated by reset so nothing is accepted while nRST is held low.
  always_comb begin
    grant = 2'b00;
    if (nRST && !stall) begin
      if (bothValid) begin
        grant = lastGrantReg ? 2'b01 : 2'b10;
      end else begin
        grant = reqValid;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign transfer   = grant[0] || grant[1];
  assign grantIdx   = grant[1];

`ifdef RFARB_R0_ZERO_EN
  assign dropWrite = (reqAddr[grantIdx] == '0);
`else
  assign dropWrite = 1'b0;
`endif

  always_comb begin
    lastGrantNext   = lastGrantReg;
    writeEnableNext = 1'b0;
    writeAddrNext   = writeAddrReg;
    writeDataNext   = writeDataReg;
    conflictNext    = conflictReg;
    if (transfer) begin
      lastGrantNext = grantIdx;
      if (!dropWrite) begin
        writeEnableNext = 1'b1;
        writeAddrNext   = reqAddr[grantIdx];
        writeDataNext   = reqData[grantIdx];
      end
    end
    if (bothValid && !stall && (conflictReg != {CNT_W{1'b1}})) begin
      conflictNext = conflictReg + CNT_W'(1);
    end
  end

  // Reset value 1 for the pointer lets requester 0 win the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lastGrantReg   <= 1'b1;
      writeEnableReg <= 1'b0;
      writeAddrReg   <= '0;
      writeDataReg   <= '0;
      conflictReg    <= '0;
    end else begin
      lastGrantReg   <= lastGrantNext;
      writeEnableReg <= writeEnableNext;
      writeAddrReg   <= writeAddrNext;
      writeDataReg   <= writeDataNext;
      conflictReg    <= conflictNext;
    end
  end

  assign writeEnable  = writeEnableReg;
  assign writeAddr    = writeAddrReg;
  assign writeData    = writeDataReg;
  assign last_grant   = lastGrantReg;
  assign conflict_cnt = conflictReg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter; inputs change on the falling edge,
// combinational ready is checked just after, registered outputs on the next falling edge.
module tb_regfile_wr_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;

  logic              CLK;
  logic              nRST;
  logic              stall;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic              last_grant;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0;
    idleInputs();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  logic [DATA_W-1:0] d0, d1;
  int expGrant;

  initial begin
    nRST = 1'b0;
    idleInputs();
    req0_valid = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checkVal("rst_ready0", req0_ready, 1'b0);
    checkVal("rst_we", writeEnable, 1'b0);
    checkVal("rst_addr", writeAddr, 4'h0);
    checkVal("rst_data", writeData, 16'h0);
    checkVal("rst_lastgrant", last_grant, 1'b1);
    checkVal("rst_cnt", conflict_cnt, 8'd0);
    @(negedge CLK);
    idleInputs();
    nRST = 1'b1;

    // Single requester write
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h00A5;
    $display("txn single req0 addr=3 data=00a5");
    #1;
    checkVal("single_ready0", req0_ready, 1'b1);
    checkVal("single_ready1", req1_ready, 1'b0);
    @(negedge CLK);
    checkVal("single_we", writeEnable, 1'b1);
    checkVal("single_addr", writeAddr, 4'd3);
    checkVal("single_data", writeData, 16'h00A5);
    checkVal("single_lastgrant", last_grant, 1'b0);
    req0_valid = 1'b0;
    @(negedge CLK);
    checkVal("single_we_off", writeEnable, 1'b0);
    checkVal("single_addr_hold", writeAddr, 4'd3);

    // Continuous contention from reset: grants alternate 0,1,0,1
    doReset();
    d0 = 16'h1111; d1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        checkVal("rr_we", writeEnable, 1'b1);
        checkVal("rr_addr", writeAddr, (expGrant == 0) ? 4'd1 : 4'd2);
        checkVal("rr_data", writeData, (expGrant == 0) ? d0 - 16'd1 : d1 - 16'd1);
      end
      req0_valid = 1'b1; req0_addr = 4'd1; req0_data = d0;
      req1_valid = 1'b1; req1_addr = 4'd2; req1_data = d1;
      expGrant = k % 2;
      $display("txn contention k=%0d d0=%0h d1=%0h expect grant %0d", k, d0, d1, expGrant);
      #1;
      checkVal("rr_ready0", req0_ready, (expGrant == 0) ? 1'b1 : 1'b0);
      checkVal("rr_ready1", req1_ready, (expGrant == 1) ? 1'b1 : 1'b0);
      if (expGrant == 0) d0 = d0 + 16'd1; else d1 = d1 + 16'd1;
      @(negedge CLK);
    end
    checkVal("rr_we_last", writeEnable, 1'b1);
    checkVal("rr_data_last", writeData, d1 - 16'd1);
    checkVal("rr_lastgrant", last_grant, 1'b1);
    checkVal("rr_cnt", conflict_cnt, 8'd4);
    idleInputs();
    @(negedge CLK);
    checkVal("rr_we_off", writeEnable, 1'b0);

    // Stall blocks both, counter frozen, requester 0 wins after release
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h5555;
    req1_valid = 1'b1; req1_addr = 4'd6; req1_data = 16'h6666;
    for (int k = 0; k < 3; k++) begin
      $display("txn stalled cycle %0d", k);
      #1;
      checkVal("stall_ready0", req0_ready, 1'b0);
      checkVal("stall_ready1", req1_ready, 1'b0);
      @(negedge CLK);
      checkVal("stall_we", writeEnable, 1'b0);
    end
    checkVal("stall_cnt", conflict_cnt, 8'd4);
    stall = 1'b0;
    $display("txn stall released");
    #1;
    checkVal("release_ready0", req0_ready, 1'b1);
    checkVal("release_ready1", req1_ready, 1'b0);
    @(negedge CLK);
    checkVal("release_addr", writeAddr, 4'd5);
    checkVal("release_cnt", conflict_cnt, 8'd5);
    idleInputs();

    // Asynchronous reset while a write is in the output register
    req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 16'hBEEF;
    $display("txn req1 addr=7 data=beef then reset");
    @(negedge CLK);
    req1_valid = 1'b0;
    checkVal("prerst_we", writeEnable, 1'b1);
    checkVal("prerst_data", writeData, 16'hBEEF);
    #1;
    nRST = 1'b0;
    #1;
    checkVal("arst_we", writeEnable, 1'b0);
    checkVal("arst_addr", writeAddr, 4'd0);
    checkVal("arst_data", writeData, 16'h0);
    checkVal("arst_lastgrant", last_grant, 1'b1);
    checkVal("arst_cnt", conflict_cnt, 8'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Saturation of the contention counter
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'h0101;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h0202;
    $display("txn saturation run start");
    repeat (254) @(negedge CLK);
    checkVal("sat_cnt_254", conflict_cnt, 8'd254);
    repeat (46) @(negedge CLK);
    checkVal("sat_cnt_300", conflict_cnt, 8'd255);
    idleInputs();

    // Write to register 0
    doReset();
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 16'hFFFF;
    $display("txn req1 addr=0 data=ffff");
    #1;
    checkVal("r0_ready1", req1_ready, 1'b1);
    @(negedge CLK);
    req1_valid = 1'b0;
    checkVal("r0_lastgrant", last_grant, 1'b1);
    checkVal("r0_addr", writeAddr, 4'd0);
`ifdef RFARB_R0_ZERO_EN
    checkVal("r0_we", writeEnable, 1'b0);
`else
    checkVal("r0_we", writeEnable, 1'b1);
    checkVal("r0_data", writeData, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter that shares the single write port of the 16 x 16-bit register file between two writeback requesters, for example the ALU and the load unit. Each requester presents address and data with a valid/ready handshake. The arbiter registers the winning request and drives writeEnable, writeAddr and writeData into the register file one cycle later. It also keeps a saturating count of contention cycles for performance debug.

## Interface
Parameters:
- DATA_W, 16, write data width
- ADDR_W, 4, register address width (16 entries)
- CNT_W, 8, contention counter width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- stall  in  1  when high, no request is granted
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1
- writeEnable  out  1  register file write strobe (registered)
- writeAddr  out  ADDR_W  register file write address (registered)
- writeData  out  DATA_W  register file write data (registered)
- last_grant  out  1  requester that won the most recent grant
- conflict_cnt  out  CNT_W  saturating count of cycles with both requesters valid and not stalled

## Operation
Handshake:
- A transfer on port i occurs in a cycle where reqi_valid and reqi_ready are both high at the rising edge.
- reqi_ready is combinational from the valid inputs, stall and the priority pointer. It is never high while reqi_valid is low.
- A requester must hold valid, addr and data stable until ready is seen.

Arbitration:
- If stall is high, both ready outputs are low.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester not equal to last_grant is granted (round-robin). At most one ready is high per cycle.

Priority pointer (last_grant):
- Updates to the granted index on every transfer.
- Holds its value when there is no transfer.

Output register:
- On a transfer, writeEnable <= 1, and writeAddr and writeData <= the granted requester's addr and data.
- With no transfer, writeEnable <= 0. writeAddr and writeData hold their previous values.

Contention counter:
- conflict_cnt increments in any cycle with req0_valid && req1_valid && !stall.
- It saturates at 2^CNT_W-1 and never wraps.

Ordering:
- Writes reach the register file in acceptance order.
- Two writes to the same address in consecutive cycles both appear; the later one wins in the register file.

## Timing
- Reset: writeEnable=0, writeAddr=0, writeData=0, last_grant=1 (so requester 0 wins the first tie), conflict_cnt=0, ready outputs low while nRST is low.
- Reset asserted mid-transfer clears the output register immediately. A write captured but not yet applied is lost.
- Latency:
  - Accept at edge N.
  - writeEnable is high during cycle N..N+1.
  - The register file captures the write at edge N+1.
- Throughput is one write per cycle total. Under continuous contention each requester gets every other cycle.
- stall asserted takes effect in the same cycle (combinational). The write already in the output register still completes.
- Back-to-back transfers keep writeEnable continuously high, with no bubble.

## Configuration
- RFARB_R0_ZERO_EN
  - Defined: register 0 is hard-wired to zero. Requests to address 0 are still accepted (ready asserted, pointer and counter update as normal), but writeEnable stays 0 for that transfer.
  - Undefined: address 0 is written like any other register.

## Test plan
- Reset, then req0 valid only, addr=3, data=0x00A5 -> req0_ready=1 the same cycle; the next cycle writeEnable=1, writeAddr=3, writeData=0x00A5; then writeEnable=0.
- Both valid for 4 cycles (req0 addr=1/data=0x1111, req1 addr=2/data=0x2222, new data each accept) -> grant order 0,1,0,1; writeEnable high 4 consecutive cycles; conflict_cnt=4.
- Both valid with stall=1 for 3 cycles, then released -> no ready while stalled; conflict_cnt unchanged; requester 0 granted first after release.
- nRST pulsed low while writeEnable=1 (writeData=0xBEEF) -> writeEnable, writeAddr and writeData go to 0 immediately; last_grant=1; conflict_cnt=0.
- Hold both valid for 300 cycles with CNT_W=8 -> conflict_cnt stops at 255.
- With RFARB_R0_ZERO_EN defined, req1 addr=0, data=0xFFFF -> req1_ready=1; writeEnable stays 0; last_grant=1. Without the macro -> writeEnable=1, writeAddr=0.
